// File: rtl/discharge_param_scheduler.sv
// Parameter scheduler for the pulse generator: synchronises command strobes, holds pending
// updates and commits them atomically at period boundaries; also emits periodic feedback.
module discharge_param_scheduler #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STOP_TIMEOUT  = 1024,
  parameter int unsigned FB_DIV        = 16,
  parameter int unsigned FB_ACK_CYCLES = 8,
  parameter int unsigned TON_MIN       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        machine_start_ack,
  input  logic        machine_stop_ack,
  input  logic [15:0] Ton_data_async,
  input  logic        change_Ton_ack,
  input  logic [15:0] Toff_data_async,
  input  logic        change_Toff_ack,
  input  logic [15:0] Ip_data_async,
  input  logic        change_Ip_ack,
  input  logic [15:0] waveform_data_async,
  input  logic        change_waveform_ack,
  input  logic        period_end,
  input  logic [31:0] feedback_in,
  output logic        machine_en,
  output logic [15:0] Ton,
  output logic [15:0] Toff,
  output logic [15:0] Ip,
  output logic [15:0] waveform,
  output logic        param_update,
  output logic [31:0] feedback_data_async,
  output logic        change_feedback_ack,
  output logic        busy
);

  localparam int unsigned TO_W  = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT) : 1;
  localparam int unsigned FB_W  = (FB_DIV > 1) ? $clog2(FB_DIV) : 1;
  localparam int unsigned ACK_W = $clog2(FB_ACK_CYCLES + 1);
  localparam logic [15:0]      MIN16   = 16'(TON_MIN);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(STOP_TIMEOUT - 1);
  localparam logic [FB_W-1:0]  FB_LAST = FB_W'(FB_DIV - 1);
  localparam logic [ACK_W-1:0] ACK_INI = ACK_W'(FB_ACK_CYCLES - 1);

  typedef enum logic [1:0] {StStopped, StStarting, StRunning, StStopping} state_e;

  state_e           r_state, w_state_d;
  logic [5:0]       w_strb_async;
  logic [5:0]       r_sync [SYNC_STAGES];
  logic [5:0]       r_sync_prev, r_evt;
  logic             w_start, w_stop;
  logic [3:0]       w_cap, r_pend;
  logic [15:0]      w_data [4];
  logic [15:0]      r_sh [4];
  logic [15:0]      w_ton_cl, w_toff_cl;
  logic             w_commit_en, w_commit;
  logic [TO_W-1:0]  r_to_cnt;
  logic [FB_W-1:0]  r_fb_cnt;
  logic             w_wrap, r_fb_launch;
  logic [ACK_W-1:0] r_ack_cnt;

  assign w_strb_async = {change_waveform_ack, change_Ip_ack, change_Toff_ack, change_Ton_ack,
                         machine_stop_ack, machine_start_ack};

  // Registered rising-edge detect after the synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sync_prev <= '0;
      r_evt       <= '0;
    end else begin
      r_sync[0] <= w_strb_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_evt       <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    end
  end

  assign w_start = r_evt[0] & ~r_evt[1];
  assign w_stop  = r_evt[1];
  assign w_cap   = r_evt[5:2];

  assign w_data[0] = Ton_data_async;
  assign w_data[1] = Toff_data_async;
  assign w_data[2] = Ip_data_async;
  assign w_data[3] = waveform_data_async;

  assign w_ton_cl  = (r_sh[0] < MIN16) ? MIN16 : r_sh[0];
  assign w_toff_cl = (r_sh[1] < MIN16) ? MIN16 : r_sh[1];

  always_comb begin
    w_state_d   = r_state;
    w_commit_en = 1'b0;
    unique case (r_state)
      StStopped: begin
        w_commit_en = 1'b1;
        if (w_start) w_state_d = StStarting;
      end
      StStarting: begin
        w_commit_en = 1'b1;
        w_state_d   = StRunning;
      end
      StRunning: begin
        w_commit_en = period_end;
        if (w_stop) w_state_d = StStopping;
      end
      StStopping: begin
        if (period_end || (r_to_cnt == TO_LAST)) begin
          w_commit_en = 1'b1;
          w_state_d   = StStopped;
        end
      end
      default: w_state_d = StStopped;
    endcase
  end

  assign w_commit   = w_commit_en & (|r_pend);
  assign machine_en = (r_state == StRunning) || (r_state == StStopping);
  assign busy       = (r_state == StStarting) || (r_state == StStopping);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StStopped;
      r_to_cnt     <= '0;
      r_pend       <= '0;
      for (int i = 0; i < 4; i++) r_sh[i] <= '0;
      Ton          <= 16'd80;
      Toff         <= 16'd20;
      Ip           <= 16'd30;
      waveform     <= 16'd0;
      param_update <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_to_cnt     <= (r_state == StStopping) ? r_to_cnt + 1'b1 : '0;
      param_update <= w_commit;
      if (w_commit) begin
        if (r_pend[0]) Ton      <= w_ton_cl;
        if (r_pend[1]) Toff     <= w_toff_cl;
        if (r_pend[2]) Ip       <= r_sh[2];
        if (r_pend[3]) waveform <= r_sh[3];
      end
      // A capture on the commit cycle stays pending for the next commit
      for (int i = 0; i < 4; i++) begin
        if (w_cap[i]) begin
          r_sh[i]   <= w_data[i];
          r_pend[i] <= 1'b1;
        end else if (w_commit) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  assign w_wrap = (r_state == StRunning) && period_end && (r_fb_cnt == FB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fb_cnt            <= '0;
      r_fb_launch         <= 1'b0;
      r_ack_cnt           <= '0;
      feedback_data_async <= '0;
      change_feedback_ack <= 1'b0;
    end else begin
      if (r_state != StRunning) r_fb_cnt <= '0;
      else if (period_end)      r_fb_cnt <= w_wrap ? '0 : r_fb_cnt + 1'b1;
      // Snapshot frozen from launch until ack drops; wraps in that window are dropped
      if (w_wrap && !r_fb_launch && !change_feedback_ack) begin
        feedback_data_async <= feedback_in;
        r_fb_launch         <= 1'b1;
      end else begin
        r_fb_launch <= 1'b0;
      end
      if (r_fb_launch) begin
        change_feedback_ack <= 1'b1;
        r_ack_cnt           <= ACK_INI;
      end else if (change_feedback_ack) begin
        if (r_ack_cnt == '0) change_feedback_ack <= 1'b0;
        else                 r_ack_cnt <= r_ack_cnt - 1'b1;
      end
    end
  end

endmodule
